// File: rtl/ahb_slave_port_mux.sv
// AHB slave-side port multiplexer.
// Steers the granted master's address/control onto the slave, tracks the
// address/data pipeline so write data and responses reach the right master,
// and counts burst beats to report hwait/hlast back to the arbiter.

package ahb_package;
    typedef logic [2:0] burst_type;

    localparam burst_type BURST_SINGLE = 3'd0;
    localparam burst_type BURST_INCR   = 3'd1;
    localparam burst_type BURST_WRAP4  = 3'd2;
    localparam burst_type BURST_INCR4  = 3'd3;
    localparam burst_type BURST_WRAP8  = 3'd4;
    localparam burst_type BURST_INCR8  = 3'd5;
    localparam burst_type BURST_WRAP16 = 3'd6;
    localparam burst_type BURST_INCR16 = 3'd7;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;
endpackage

module ahb_slave_port_mux
    import ahb_package::*;
#(
    parameter int MASTER_NUM = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                                 hclk,
    input  logic                                 hreset_n,
    input  logic [MASTER_NUM-1:0]                hgrant,
    input  logic [MASTER_NUM-1:0][ADDR_W-1:0]    m_haddr,
    input  logic [MASTER_NUM-1:0][1:0]           m_htrans,
    input  burst_type [MASTER_NUM-1:0]           m_hburst,
    input  logic [MASTER_NUM-1:0]                m_hwrite,
    input  logic [MASTER_NUM-1:0][2:0]           m_hsize,
    input  logic [MASTER_NUM-1:0][DATA_W-1:0]    m_hwdata,
    output logic                                 s_hsel,
    output logic [ADDR_W-1:0]                    s_haddr,
    output logic [1:0]                           s_htrans,
    output burst_type                            s_hburst,
    output logic                                 s_hwrite,
    output logic [2:0]                           s_hsize,
    output logic [DATA_W-1:0]                    s_hwdata,
    input  logic                                 s_hreadyout,
    input  logic                                 s_hresp,
    input  logic [DATA_W-1:0]                    s_hrdata,
    output logic [MASTER_NUM-1:0]                m_hready,
    output logic [MASTER_NUM-1:0]                m_hresp,
    output logic [DATA_W-1:0]                    m_hrdata,
    output logic                                 hwait,
    output logic [MASTER_NUM-1:0]                hlast
);

    typedef enum logic {
        IDLE_B = 1'b0,
        BURST  = 1'b1
    } beat_state_t;

    // Beats remaining after the first one for each fixed-length burst type.
    function automatic logic [3:0] burst_len(input burst_type b);
        case (b)
            BURST_WRAP4,  BURST_INCR4:  burst_len = 4'd3;
            BURST_WRAP8,  BURST_INCR8:  burst_len = 4'd7;
            BURST_WRAP16, BURST_INCR16: burst_len = 4'd15;
            BURST_SINGLE, BURST_INCR:   burst_len = 4'd0;
            default:                    burst_len = 4'd0;
        endcase
    endfunction

    logic [MASTER_NUM-1:0] addr_owner_s;
    logic [MASTER_NUM-1:0] data_owner_s;
    logic [MASTER_NUM-1:0] data_owner_r;
    logic                  err_cancel_r;
    logic                  has_owner_s;
    logic [ADDR_W-1:0]     haddr_mux_s;
    logic [1:0]            trans_mux_s;
    burst_type             burst_mux_s;
    logic                  hwrite_mux_s;
    logic [2:0]            hsize_mux_s;
    logic [DATA_W-1:0]     hwdata_mux_s;
    logic [1:0]            htrans_s;
    beat_state_t           state_r;
    beat_state_t           state_n;
    logic [3:0]            remain_r;
    logic [3:0]            remain_n;
    logic                  incr_active_r;
    logic                  incr_n;
    logic                  last_s;

    // Owners are masked while reset is held so every output sits at its reset value.
    always_comb begin
        addr_owner_s = hreset_n ? hgrant : {MASTER_NUM{1'b0}};
        data_owner_s = hreset_n ? data_owner_r : {MASTER_NUM{1'b0}};
        has_owner_s  = |addr_owner_s;
    end

    // One-hot AND-OR mux of the address phase and of the write data.
    always_comb begin
        haddr_mux_s  = {ADDR_W{1'b0}};
        trans_mux_s  = 2'd0;
        burst_mux_s  = 3'd0;
        hwrite_mux_s = 1'b0;
        hsize_mux_s  = 3'd0;
        hwdata_mux_s = {DATA_W{1'b0}};
        for (int i = 0; i < MASTER_NUM; i++) begin
            haddr_mux_s  = haddr_mux_s  | (m_haddr[i]  & {ADDR_W{addr_owner_s[i]}});
            trans_mux_s  = trans_mux_s  | (m_htrans[i] & {2{addr_owner_s[i]}});
            burst_mux_s  = burst_mux_s  | (m_hburst[i] & {3{addr_owner_s[i]}});
            hwrite_mux_s = hwrite_mux_s | (m_hwrite[i] & addr_owner_s[i]);
            hsize_mux_s  = hsize_mux_s  | (m_hsize[i]  & {3{addr_owner_s[i]}});
            hwdata_mux_s = hwdata_mux_s | (m_hwdata[i] & {DATA_W{data_owner_s[i]}});
        end
        htrans_s = (err_cancel_r || !has_owner_s) ? HTRANS_IDLE : trans_mux_s;
    end

    // Data-phase owner follows accepted transfers; err_cancel marks the second ERROR cycle.
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            data_owner_r <= {MASTER_NUM{1'b0}};
            err_cancel_r <= 1'b0;
        end else begin
            if (s_hreadyout) begin
                data_owner_r <= htrans_s[1] ? addr_owner_s : {MASTER_NUM{1'b0}};
            end else begin
                data_owner_r <= data_owner_r;
            end
            err_cancel_r <= s_hresp & ~s_hreadyout & ~err_cancel_r;
        end
    end

    // Beat counter state register.
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state_r       <= IDLE_B;
            remain_r      <= 4'd0;
            incr_active_r <= 1'b0;
        end else begin
            state_r       <= state_n;
            remain_r      <= remain_n;
            incr_active_r <= incr_n;
        end
    end

    // Beat counter next state and final-beat detection.
    always_comb begin
        state_n  = state_r;
        remain_n = remain_r;
        incr_n   = incr_active_r;
        last_s   = 1'b0;
        if (err_cancel_r) begin
            state_n  = IDLE_B;
            remain_n = 4'd0;
            incr_n   = 1'b0;
        end else if (s_hreadyout && has_owner_s) begin
            // An undefined-length burst ends when its owner stops issuing SEQ/BUSY.
            if (incr_active_r && ((trans_mux_s == HTRANS_IDLE) || (trans_mux_s == HTRANS_NONSEQ))) begin
                last_s  = 1'b1;
                incr_n  = 1'b0;
                state_n = IDLE_B;
            end else begin
                last_s = 1'b0;
            end
            case (trans_mux_s)
                HTRANS_NONSEQ: begin
                    if (burst_mux_s == BURST_INCR) begin
                        state_n  = BURST;
                        remain_n = 4'd0;
                        incr_n   = 1'b1;
                    end else begin
                        remain_n = burst_len(burst_mux_s);
                        incr_n   = 1'b0;
                        state_n  = (remain_n == 4'd0) ? IDLE_B : BURST;
                        last_s   = last_s | (remain_n == 4'd0);
                    end
                end
                HTRANS_SEQ: begin
                    if ((state_r == BURST) && !incr_active_r) begin
                        remain_n = remain_r - 4'd1;
                        state_n  = (remain_n == 4'd0) ? IDLE_B : BURST;
                        last_s   = last_s | (remain_n == 4'd0);
                    end else begin
                        remain_n = remain_r;
                    end
                end
                HTRANS_BUSY: remain_n = remain_r;
                default:     remain_n = remain_r;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    assign s_hsel   = has_owner_s;
    assign s_haddr  = haddr_mux_s;
    assign s_htrans = htrans_s;
    assign s_hburst = burst_mux_s;
    assign s_hwrite = hwrite_mux_s;
    assign s_hsize  = hsize_mux_s;
    assign s_hwdata = hwdata_mux_s;
    assign m_hready = (addr_owner_s | data_owner_s) & {MASTER_NUM{s_hreadyout}};
    assign m_hresp  = data_owner_s & {MASTER_NUM{s_hresp}};
    assign m_hrdata = s_hrdata;
    assign hwait    = (|data_owner_s) & ~s_hreadyout;
    assign hlast    = addr_owner_s & {MASTER_NUM{last_s}};

endmodule

// File: doc/ahb_slave_port_mux.md
# ahb_slave_port_mux

Slave-side port multiplexer that sits directly downstream of the per-slave arbiter. It takes the arbiter's one-hot grant and steers the granted master's address/control onto the slave. It tracks the AHB address/data pipeline so write data and responses reach the correct master. It also counts burst beats and returns `hwait` and per-master `hlast` to the arbiter.

## Interface
- `MASTER_NUM`, 2: masters competing for this slave.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `hclk` in 1: clock.
- `hreset_n` in 1: reset, synchronous, active-low.
- `hgrant` in MASTER_NUM: one-hot or zero address-phase grant from the arbiter.
- `m_haddr` in MASTER_NUM×ADDR_W: per-master address.
- `m_htrans` in MASTER_NUM×2: per-master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `m_hburst` in MASTER_NUM×`burst_type`: per-master burst type (AHB_package encoding).
- `m_hwrite` in MASTER_NUM: per-master write flag.
- `m_hsize` in MASTER_NUM×3: per-master transfer size.
- `m_hwdata` in MASTER_NUM×DATA_W: per-master write data.
- `s_hsel` out 1: slave select.
- `s_haddr` out ADDR_W: muxed address to the slave.
- `s_htrans` out 2: muxed transfer type to the slave.
- `s_hburst` out `burst_type`: muxed burst type to the slave.
- `s_hwrite` out 1: muxed write flag to the slave.
- `s_hsize` out 3: muxed transfer size to the slave.
- `s_hwdata` out DATA_W: muxed write data to the slave.
- `s_hreadyout` in 1: slave ready.
- `s_hresp` in 1: slave response (0=OKAY, 1=ERROR).
- `s_hrdata` in DATA_W: slave read data.
- `m_hready` out MASTER_NUM: per-master ready.
- `m_hresp` out MASTER_NUM: per-master response.
- `m_hrdata` out DATA_W: read data broadcast to all masters.
- `hwait` out 1: data phase stalled, to the arbiter.
- `hlast` out MASTER_NUM: final beat of the owner's burst, to the arbiter.

## Operation
- **Address mux (combinational).**
  - `addr_owner = hgrant`.
  - `s_haddr/s_hburst/s_hwrite/s_hsize` select the owner's inputs; all zero when there is no owner.
  - `s_htrans` is the owner's `m_htrans`, forced to IDLE when there is no owner or `err_cancel`=1.
  - `s_hsel` = `|addr_owner`.
- **Data-phase register `data_owner` (MASTER_NUM bits).**
  - Updates only when `s_hreadyout`=1.
  - Loads `addr_owner` if `s_htrans` is NONSEQ or SEQ; otherwise loads 0.
  - `s_hwdata` is muxed by `data_owner`; it is 0 when `data_owner` is 0.
- **Responses.**
  - `m_hready[i]` = `s_hreadyout` if `addr_owner[i]|data_owner[i]`, else 0.
  - `m_hresp[i]` = `data_owner[i] ? s_hresp : 0`.
  - `m_hrdata` = `s_hrdata`.
  - `hwait` = `(|data_owner) & ~s_hreadyout`.
- **Error handling.**
  - `err_cancel` sets on the first ERROR cycle (`s_hresp`=1, `s_hreadyout`=0) and clears the next cycle.
  - While `err_cancel` is set, the pending address phase is driven IDLE and the beat counter is cleared.
- **Beat counter, 4-bit `remain` plus `incr_active` flag.**
  - State IDLE_B to BURST on an accepted NONSEQ (`s_hreadyout`=1): `remain` loads SINGLE→0, WRAP4/INCR4→3, WRAP8/INCR8→7, WRAP16/INCR16→15. INCR sets `incr_active` instead.
  - Each accepted SEQ decrements `remain`. BUSY and stalled cycles hold it.
  - BURST to IDLE_B when the final beat is accepted, or on `err_cancel`.
  - A NONSEQ accepted while in BURST restarts the count; the new burst overrides.
- **hlast.** `hlast[i]` = `addr_owner[i]` & accepted NONSEQ/SEQ & the beat is final:
  - For fixed bursts, the beat is final when `remain` after load or decrement equals 0.
  - For INCR, `hlast` pulses in the first cycle the owner presents IDLE or NONSEQ while `incr_active`=1; `incr_active` then clears.

## Timing
- Address and control paths are zero-latency from `hgrant`/`m_*` to `s_*`.
- Write data, responses and `hready` steering lag the address phase by one accepted cycle.
- **Reset** (`hreset_n`=0 at a `hclk` edge) clears `data_owner`, `err_cancel`, `remain`, `incr_active` and the state (IDLE_B). With no grant this gives:
  - `s_htrans`=IDLE, `s_hsel`=0, `s_hwdata`=0;
  - `m_hready`=0, `m_hresp`=0;
  - `hwait`=0, `hlast`=0.
- **Reset mid-burst** aborts tracking immediately. There is no drain.
- **Grant change with a stalled data phase:** `data_owner` holds, and the new owner sees `m_hready`=0 until the slave is ready.
- **Same master in both phases** sees a single `m_hready`.

## Test plan
- Reset with `hgrant`=01 and master0 driving NONSEQ: during reset all outputs are at reset values. After release, `s_htrans`=2, `s_haddr`=master0 address, and `data_owner`=01 one cycle later.
- Master1 INCR4 write at 0x100, `s_hreadyout`=1 throughout: four beats pass with `s_hwdata` lagging one cycle. `hlast`=10 only on the 4th address beat. No `hwait`.
- Master0 single read; the slave inserts 2 wait states with `s_hrdata`=0xA5A5: `hwait`=1 for 2 cycles, `m_hready`=00 for those cycles, then `m_hready[0]`=1 with `m_hrdata`=0xA5A5.
- Master0 WRAP8 read with a BUSY on beat 3: `remain` holds on BUSY, and `hlast` asserts on the 8th accepted beat, not the 9th address cycle.
- Master1 INCR of 5 SEQ beats, then IDLE: `hlast`=10 for exactly one cycle, the first IDLE cycle.
- Slave ERROR on beat 2 of an INCR8: `m_hresp[owner]`=1 for 2 cycles. The address during the second ERROR cycle is driven IDLE, the counter returns to IDLE_B, and `hlast` stays 0.
